// File: rtl/approx_adder_err_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : approx_adder_err_sched_if
// Description : Bus between the approximate-adder error sequencer and the
//               characterisation harness. The harness holds the adder under
//               test and the run controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface approx_adder_err_sched_if #(
  parameter int N     = 16,
  parameter int CNT_W = 16
);
  logic               start;
  logic               mode;
  logic               abort;
  logic [N-1:0]       op_a;
  logic [N-1:0]       op_b;
  logic [N-1:0]       approx_s;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   err_count;
  logic [CNT_W-1:0]   hi_err_count;
  logic [N-1:0]       max_ed;
  logic [N+CNT_W-1:0] sum_ed;

  // Sequencer side
  modport slave (
    input  start, mode, abort, approx_s,
    output op_a, op_b, busy, done, err_count, hi_err_count, max_ed, sum_ed
  );

  // Harness side: run controls plus the adder under test
  modport master (
    output start, mode, abort, approx_s,
    input  op_a, op_b, busy, done, err_count, hi_err_count, max_ed, sum_ed
  );
endinterface
`default_nettype wire

// File: rtl/approx_adder_err_sched.sv
`default_nettype none
// ============================================================================
// Module      : approx_adder_err_sched
// Description : Drives operand pairs into an external combinational
//               approximate adder. It compares each returned sum with the
//               exact N-bit sum and accumulates error statistics over a run
//               of NUM_SAMPLES pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_adder_err_sched #(
  parameter int          N           = 16,
  parameter int          K           = 12,
  parameter int          NUM_SAMPLES = 256,
  parameter int          CNT_W       = 16,
  parameter logic [15:0] SEED_A      = 16'hACE1,
  parameter logic [15:0] SEED_B      = 16'h1D2B
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  approx_adder_err_sched_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q;
  logic               mode_q;
  logic [15:0]        lfsr_a_q, lfsr_b_q;
  logic [15:0]        lfsr_a_d, lfsr_b_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       op_a_q, op_b_q;
  logic               busy_q, done_q;
  logic [CNT_W-1:0]   err_q, hi_err_q;
  logic [N-1:0]       max_ed_q;
  logic [N+CNT_W-1:0] sum_ed_q;

  logic [N-1:0]       exact_w;
  logic [N-1:0]       ed_w;
  logic               ed_nz_w;
  logic               hi_mis_w;

  // Fibonacci x^16+x^14+x^13+x^11+1: shift left, feedback into bit 0
  assign lfsr_a_d = {lfsr_a_q[14:0], lfsr_a_q[15] ^ lfsr_a_q[13] ^ lfsr_a_q[12] ^ lfsr_a_q[10]};
  assign lfsr_b_d = {lfsr_b_q[14:0], lfsr_b_q[15] ^ lfsr_b_q[13] ^ lfsr_b_q[12] ^ lfsr_b_q[10]};
  assign idx_d    = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // The adder under test has no carry-out, so the reference wraps at 2^N too
  assign exact_w  = op_a_q + op_b_q;
  assign ed_w     = (exact_w >= bus.approx_s) ? (exact_w - bus.approx_s)
                                              : (bus.approx_s - exact_w);
  assign ed_nz_w  = (ed_w != '0);
  assign hi_mis_w = (exact_w[N-1:K] != bus.approx_s[N-1:K]);

  // Run sequencer: IDLE/DONE -> (DRIVE -> SAMPLE)*NUM_SAMPLES -> DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      lfsr_a_q <= SEED_A;
      lfsr_b_q <= SEED_B;
      idx_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
      hi_err_q <= '0;
      max_ed_q <= '0;
      sum_ed_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q  <= S_DRIVE;
            mode_q   <= bus.mode;
            lfsr_a_q <= SEED_A;
            lfsr_b_q <= SEED_B;
            idx_q    <= '0;
            err_q    <= '0;
            hi_err_q <= '0;
            max_ed_q <= '0;
            sum_ed_q <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_SAMPLE;
            if (!mode_q) begin
              op_a_q   <= lfsr_a_q[N-1:0];
              op_b_q   <= lfsr_b_q[N-1:0];
              lfsr_a_q <= lfsr_a_d;
              lfsr_b_q <= lfsr_b_d;
            end else begin
              op_a_q <= idx_q[N-1:0];
              op_b_q <= idx_q[N-1:0];
            end
          end
        end
        S_SAMPLE: begin
          // An abort in this cycle discards the sample being evaluated
          if (bus.abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            err_q    <= err_q + {{(CNT_W-1){1'b0}}, ed_nz_w};
            hi_err_q <= hi_err_q + {{(CNT_W-1){1'b0}}, hi_mis_w};
            sum_ed_q <= sum_ed_q + {{CNT_W{1'b0}}, ed_w};
            if (ed_w > max_ed_q) max_ed_q <= ed_w;
            idx_q    <= idx_d;
            if (idx_d == CNT_W'(NUM_SAMPLES)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DRIVE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_a         = op_a_q;
  assign bus.op_b         = op_b_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err_count    = err_q;
  assign bus.hi_err_count = hi_err_q;
  assign bus.max_ed       = max_ed_q;
  assign bus.sum_ed       = sum_ed_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_err_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_adder_err_sched
// Description : Self-checking bench for approx_adder_err_sched. It models
//               several adders under test and predicts the run statistics
//               from plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_adder_err_sched;

  localparam int NS = 4;

  logic clk;
  logic rst_n;
  int   adder_kind;
  int   n_tests;
  int   n_fail;

  logic [15:0] exp_a [NS];
  logic [15:0] exp_b [NS];
  longint      exp_err, exp_hi, exp_max, exp_sum;
  logic [15:0] obs_a0, obs_b0, obs_a1, obs_b1;

  approx_adder_err_sched_if #(.N(16), .CNT_W(16)) bus_if ();

  approx_adder_err_sched #(
    .N(16), .K(12), .NUM_SAMPLES(NS), .CNT_W(16),
    .SEED_A(16'hACE1), .SEED_B(16'h1D2B)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test: 0 exact, 1 exact|1, 2 exact^8000, 3 lower-part OR (K=12)
  function automatic logic [15:0] adder_fn(input int kind, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] e;
    e = a + b;
    case (kind)
      1:       return e | 16'h0001;
      2:       return e ^ 16'h8000;
      3:       return {a[15:12] + b[15:12], a[11:0] | b[11:0]};
      default: return e;
    endcase
  endfunction

  always_comb bus_if.approx_s = adder_fn(adder_kind, bus_if.op_a, bus_if.op_b);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lfsr_next(input int x);
    return ((x << 1) & 32'hFFFF) | (((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1);
  endfunction

  // Reference: operand list for a whole run and statistics over the first n samples
  task automatic model(input int m, input int kind, input int n);
    int la, lb, a, b, e, ap, ed;
    la = 16'hACE1; lb = 16'h1D2B;
    exp_err = 0; exp_hi = 0; exp_max = 0; exp_sum = 0;
    for (int i = 0; i < NS; i++) begin
      if (m == 0) begin
        a = la; b = lb; la = lfsr_next(la); lb = lfsr_next(lb);
      end else begin
        a = i; b = i;
      end
      exp_a[i] = a[15:0]; exp_b[i] = b[15:0];
      if (i < n) begin
        e  = (a + b) % 65536;
        ap = int'(adder_fn(kind, a[15:0], b[15:0]));
        ed = (e > ap) ? e - ap : ap - e;
        if (ed != 0) exp_err++;
        if ((e / 4096) != (ap / 4096)) exp_hi++;
        exp_sum += ed;
        if (ed > exp_max) exp_max = ed;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, {63'd0, bus_if.busy}, 64'd0);
    check_val({tag, "_done"}, {63'd0, bus_if.done}, 64'd0);
    check_val({tag, "_ops"}, {32'd0, bus_if.op_a, bus_if.op_b}, 64'd0);
    check_val({tag, "_stats"}, {bus_if.err_count, bus_if.hi_err_count, bus_if.max_ed}, 64'd0);
    check_val({tag, "_sum"}, {32'd0, bus_if.sum_ed}, 64'd0);
  endtask

  // One run: start, optional extra start / abort at a given busy cycle
  task automatic run_once(input int m, input int kind, input int abort_at, input int extra_at);
    int  busy_cnt, n_exp;
    bit  ended;
    adder_kind = kind;
    n_exp = (abort_at >= 0) ? abort_at / 2 : NS;
    model(m, kind, n_exp);
    @(negedge clk);
    bus_if.mode  = m[0];
    bus_if.start = 1'b1;
    @(negedge clk);
    busy_cnt = 0;
    ended = 1'b0;
    for (int t = 0; t < 4 * NS + 4; t++) begin
      if (!bus_if.busy) begin
        ended = 1'b1;
        break;
      end
      if (busy_cnt % 2 == 1) begin
        check_val("op_a", {48'd0, bus_if.op_a}, {48'd0, exp_a[busy_cnt / 2]});
        check_val("op_b", {48'd0, bus_if.op_b}, {48'd0, exp_b[busy_cnt / 2]});
        if (busy_cnt == 1) begin obs_a0 = bus_if.op_a; obs_b0 = bus_if.op_b; end
        if (busy_cnt == 3) begin obs_a1 = bus_if.op_a; obs_b1 = bus_if.op_b; end
      end
      bus_if.start = (busy_cnt == extra_at);
      bus_if.abort = (busy_cnt == abort_at);
      busy_cnt++;
      @(negedge clk);
      bus_if.start = 1'b0;
      bus_if.abort = 1'b0;
    end
    bus_if.start = 1'b0;
    check_val("run_ends", {63'd0, ended}, 64'd1);
    check_val("busy_len", busy_cnt, (abort_at >= 0) ? abort_at + 1 : 2 * NS);
    check_val("done", {63'd0, bus_if.done}, (abort_at >= 0) ? 64'd0 : 64'd1);
    check_val("err_count", {48'd0, bus_if.err_count}, exp_err);
    check_val("hi_err_count", {48'd0, bus_if.hi_err_count}, exp_hi);
    check_val("max_ed", {48'd0, bus_if.max_ed}, exp_max);
    check_val("sum_ed", {32'd0, bus_if.sum_ed}, exp_sum);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Directed scenarios followed by randomized runs
  initial begin
    n_tests = 0; n_fail = 0;
    adder_kind   = 0;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.mode  = 1'b0;
    bus_if.abort = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Exact adder, sweep
    run_once(1, 0, -1, -1);
    check_val("sweep_final_ops", {32'd0, bus_if.op_a, bus_if.op_b}, 64'h0003_0003);

    // exact|1: every sample off by one, high part intact
    run_once(1, 1, -1, -1);
    check_val("or1_err", {48'd0, bus_if.err_count}, 64'd4);
    check_val("or1_sum", {32'd0, bus_if.sum_ed}, 64'd4);

    // abort in DONE has no effect
    @(negedge clk); bus_if.abort = 1'b1;
    @(negedge clk); bus_if.abort = 1'b0;
    check_val("abort_in_done_done", {63'd0, bus_if.done}, 64'd1);
    check_val("abort_in_done_err", {48'd0, bus_if.err_count}, 64'd4);

    // MSB flip: high-part errors on every sample
    run_once(1, 2, -1, -1);
    check_val("msb_hi", {48'd0, bus_if.hi_err_count}, 64'd4);
    check_val("msb_max", {48'd0, bus_if.max_ed}, 64'h8000);
    check_val("msb_sum", {32'd0, bus_if.sum_ed}, 64'h0002_0000);

    // LFSR source with exact adder (third pair wraps past 2^16)
    run_once(0, 0, -1, -1);
    check_val("lfsr_a0", {48'd0, obs_a0}, 64'hACE1);
    check_val("lfsr_b0", {48'd0, obs_b0}, 64'h1D2B);
    check_val("lfsr_a1", {48'd0, obs_a1}, 64'h59C3);
    check_val("lfsr_b1", {48'd0, obs_b1}, 64'h3A56);

    // start while busy ignored; abort mid-run keeps partial statistics
    run_once(1, 1, -1, 3);
    run_once(1, 1, 5, -1);
    check_val("abort_partial_err", {48'd0, bus_if.err_count}, 64'd2);

    // Reset mid-run, then a fresh run from seed
    adder_kind = 1;
    @(negedge clk); bus_if.mode = 1'b1; bus_if.start = 1'b1;
    @(negedge clk); bus_if.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrun_reset");
    rst_n = 1'b1;
    run_once(0, 3, -1, -1);
    check_val("post_reset_a0", {48'd0, obs_a0}, 64'hACE1);

    // Randomized runs
    for (int r = 0; r < 30; r++) begin
      int m, k, ab, ex;
      m  = int'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 3));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * NS - 1)) : -1;
      ex = int'($urandom_range(1, 2 * NS - 1));
      run_once(m, k, ab, ex);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/approx_adder_err_sched.md
Name: approx_adder_err_sched

Overview:
Sequencer that characterises one external combinational approximate adder, such as the HERLOA N=16/K=12 instance. It generates operand pairs, drives them onto the adder inputs and captures the approximate sum. It compares that sum against the exact N-bit sum and accumulates error statistics. The block sits beside the adder under test in the characterisation harness and replaces hand-written operand lists with a hardware run of programmable length.

Parameters:
N, 16, operand/sum width; legal range 8..16.
K, 12, approximate-part width of the adder under test; used to split low-part and high-part error counting; legal range 1..N-1.
NUM_SAMPLES, 256, operand pairs per run; legal range 1..2^CNT_W-1.
CNT_W, 16, width of sample/error counters.
SEED_A, 16'hACE1, LFSR A seed; must be nonzero.
SEED_B, 16'h1D2B, LFSR B seed; must be nonzero.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, synchronous, active-low.
start  in  1  one-cycle pulse; begins a run when idle or done.
mode  in  1  operand source, latched at start: 0 = LFSR, 1 = sweep.
abort  in  1  terminates a run; returns to IDLE.
op_a  out  N  operand A to the adder under test (registered).
op_b  out  N  operand B to the adder under test (registered).
approx_s  in  N  adder-under-test sum, combinational from op_a/op_b.
busy  out  1  high in DRIVE/SAMPLE.
done  out  1  high in DONE; held until the next start.
err_count  out  CNT_W  samples with approx_s != exact.
hi_err_count  out  CNT_W  samples with approx_s[N-1:K] != exact[N-1:K].
max_ed  out  N  maximum error distance seen.
sum_ed  out  N+CNT_W  sum of error distances.

Behaviour:
- One clock; reset is synchronous and active-low. In the reset cycle all outputs and state go to 0, the FSM goes to IDLE, and the LFSRs load their seeds. Reset mid-run discards the run with no done.
- exact = (op_a + op_b) mod 2^N. The carry-out is dropped because the adder under test has no cout.
- ED = |exact - approx_s|, computed as an N-bit unsigned magnitude with the larger value minus the smaller.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE + start:
  - Clear all statistics and the sample index.
  - Reload the LFSRs with their seeds.
  - Latch mode; move to DRIVE.
  - done drops in the same cycle the transition registers.
- DRIVE (1 cycle):
  - Register op_a/op_b from the source.
  - mode 0: op_a = lfsrA[N-1:0], op_b = lfsrB[N-1:0]; then advance both LFSRs.
  - mode 1: op_a = op_b = idx[N-1:0].
  - Move to SAMPLE.
- SAMPLE (1 cycle):
  - The adder has settled; evaluate approx_s against exact.
  - err_count += (ED != 0).
  - hi_err_count += high-part mismatch.
  - sum_ed += ED.
  - max_ed = max(max_ed, ED).
  - idx += 1.
  - If idx+1 == NUM_SAMPLES, go to DONE; otherwise go to DRIVE.
- Throughput: 2 cycles per sample. A run of S samples has busy high for exactly 2*S cycles. done rises on the cycle after the last SAMPLE.
- LFSRs: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Shift left; bit0 = b15^b13^b12^b10.
- start while busy: ignored.
- abort while busy: go to IDLE next cycle; busy=0, done=0. Statistics hold their partial values. abort has priority over start in the same cycle. abort in IDLE/DONE has no effect.
- Statistics and op_a/op_b hold in DONE and IDLE until the next start or reset.
- Counters cannot overflow within the legal NUM_SAMPLES range; no saturation logic.

Test Plan:
- Bench adder = exact, mode 1, NUM_SAMPLES=4, start -> busy for 8 cycles, done=1; err_count=0, hi_err_count=0, max_ed=0, sum_ed=0; final op_a=op_b=3.
- Bench adder = exact|1, mode 1, NUM_SAMPLES=4 (exact 0,2,4,6) -> err_count=4, hi_err_count=0, max_ed=1, sum_ed=4.
- Bench adder = exact^16'h8000, mode 1, NUM_SAMPLES=4 -> err_count=4, hi_err_count=4, max_ed=16'h8000, sum_ed=32'h0002_0000. Separately, op pair 16'h8000+16'h8000 must give exact=0 (wrap).
- mode 0, exact adder: first DRIVE gives op_a=16'hACE1, op_b=16'h1D2B; second gives op_a=16'h59C3, op_b=16'h3A56; statistics all 0.
- Start pulse at busy cycle 3 -> ignored, run length unchanged. abort at cycle 5 -> IDLE next cycle, done=0, partial err_count held.
- rst_n=0 for one cycle mid-run -> all outputs 0 on the following edge; a new start then runs NUM_SAMPLES from seed.
